payload_csum_acc: RTL

PAYLOAD_CSUM_ACC -- requirements
Module: payload_csum_acc

---
 rtl/payload_csum_pkg.sv | 12 +
 rtl/payload_csum_lane_sum.sv | 31 +++
 rtl/payload_csum_acc.sv | 113 +++++++++++
 3 files changed

// File: rtl/payload_csum_pkg.sv
// Shared widths and helpers for the payload checksum accumulator.
package payload_csum_pkg;

  localparam int ACC_W  = 32;
  localparam int CSUM_W = 16;

  // Number of 16-bit words carried by one beat.
  function automatic int lane_cnt(input int data_w);
    return data_w / 16;
  endfunction

endpackage

// File: rtl/payload_csum_lane_sum.sv
// Per-beat word sum: masks disabled bytes to zero and adds every 16-bit
// word of the beat into a single unsigned lane sum.
module payload_csum_lane_sum
  import payload_csum_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [DATA_W-1:0]   data,
  input  logic [DATA_W/8-1:0] keep,
  output logic [ACC_W-1:0]    sum
);

  localparam int LANES = lane_cnt(DATA_W);

  logic [DATA_W-1:0] masked;

  // Zero every byte whose enable is low (odd trailing byte pads with zero).
  always_comb begin
    masked = '0;
    for (int i = 0; i < DATA_W/8; i++)
      masked[8*i +: 8] = data[8*i +: 8] & {8{keep[i]}};
  end

  // Add all masked words; at most 32 words so the sum fits comfortably.
  always_comb begin
    sum = '0;
    for (int j = 0; j < LANES; j++)
      sum = sum + ACC_W'(masked[16*j +: 16]);
  end

endmodule

// File: rtl/payload_csum_acc.sv
// Payload one's-complement checksum accumulator.
// Beat sums are accumulated per packet, folded to 16 bits in two stages
// after the eop beat, and presented with optional hold/overwrite handling.
// Build option: define PAYLOAD_CSUM_INVERT_EN to emit the inverted sum
// (a computed 0x0000 is sent as 0xFFFF).
module payload_csum_acc
  import payload_csum_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int HOLD_OUT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   s_data,
  input  logic [DATA_W/8-1:0] s_keep,
  input  logic                s_valid,
  input  logic                s_sop,
  input  logic                s_eop,
  output logic [CSUM_W-1:0]   csum_out,
  output logic                csum_valid,
  input  logic                csum_ready,
  output logic                csum_ovf,
  output logic                pkt_err
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] IN_PKT = 1'b1;

  logic [0:0]        state;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  lane_sum;
  logic              pkt_done;
  logic [1:0]        vld_pipe;
  logic [CSUM_W:0]   fold1;
  logic [CSUM_W-1:0] fold2;
  logic [CSUM_W-1:0] result;

  payload_csum_lane_sum #(.DATA_W(DATA_W)) u_lane (
    .data (s_data),
    .keep (s_keep),
    .sum  (lane_sum)
  );

  // A packet completes on any eop beat that belongs to a packet.
  assign pkt_done = s_valid && s_eop && (s_sop || state == IN_PKT);

  // Packet framing and accumulation; sop always restarts the sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      acc     <= '0;
      pkt_err <= 1'b0;
    end else begin
      pkt_err <= 1'b0;
      if (s_valid) begin
        if (s_sop) begin
          acc     <= lane_sum;
          state   <= s_eop ? IDLE : IN_PKT;
          pkt_err <= (state == IN_PKT);
        end else if (state == IN_PKT) begin
          acc   <= acc + lane_sum;
          state <= s_eop ? IDLE : IN_PKT;
        end else begin
          pkt_err <= 1'b1;
        end
      end
    end
  end

  // First fold: upper half plus lower half, registered one cycle after eop.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      fold1    <= '0;
    end else begin
      vld_pipe <= {vld_pipe[0], pkt_done};
      fold1    <= {1'b0, acc[ACC_W-1:CSUM_W]} + {1'b0, acc[CSUM_W-1:0]};
    end
  end

  // Second fold: the single possible carry can never ripple out again.
  always_comb begin
    fold2 = fold1[CSUM_W-1:0] + {{(CSUM_W-1){1'b0}}, fold1[CSUM_W]};
`ifdef PAYLOAD_CSUM_INVERT_EN
    result = (fold2 == '1) ? '1 : ~fold2;
`else
    result = fold2;
`endif
  end

  // Result register: held until accepted, or a plain pulse when not holding.
  always_ff @(posedge clk) begin
    if (rst) begin
      csum_out   <= '0;
      csum_valid <= 1'b0;
      csum_ovf   <= 1'b0;
    end else if (HOLD_OUT != 0) begin
      csum_ovf <= vld_pipe[1] && csum_valid && !csum_ready;
      if (vld_pipe[1]) begin
        csum_out   <= result;
        csum_valid <= 1'b1;
      end else if (csum_valid && csum_ready) begin
        csum_valid <= 1'b0;
      end
    end else begin
      csum_ovf   <= 1'b0;
      csum_valid <= vld_pipe[1];
      if (vld_pipe[1])
        csum_out <= result;
    end
  end

endmodule
